// File: rtl/grf_write_arbiter.sv
// Arbitrates the GRF write port between the WB stage (absolute priority) and a FIFO of
// long-latency results, and keeps a per-register pending scoreboard for the decoder.
module grf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        lb_valid,
  input  logic [4:0]  lb_addr,
  input  logic [31:0] lb_data,
  output logic        lb_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  q1_addr,
  input  logic [4:0]  q2_addr,
  output logic        q1_busy,
  output logic        q2_busy,
  output logic        stall_req,
  output logic        grf_we,
  output logic [4:0]  grf_addr,
  output logic [31:0] grf_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] AGE_MAX  = GW'(STARVE_LIMIT);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pending;
  logic [31:0]   pending_next;
  logic [GW-1:0] age;

  logic          slot_busy;
  logic          fifo_empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  // lb handshake: a transfer happens on any cycle with lb_valid && lb_ready; lb_ready
  // depends only on registered occupancy, so a full FIFO never accepts even while popping.
  // Accepted results for $0 complete the handshake but are discarded.
  always_comb begin
    slot_busy  = wb_we && (wb_addr != 5'd0);
    fifo_empty = (count == '0);
    lb_ready   = !Rst && (count < FULL_CNT);
    accept     = lb_valid && lb_ready;
    push       = accept && (lb_addr != 5'd0);
    pop        = !Rst && !slot_busy && !fifo_empty;
    head_addr  = fifo_addr[rd_ptr];
    head_data  = fifo_data[rd_ptr];
  end

  always_comb begin
    grf_we   = 1'b0;
    grf_addr = 5'd0;
    grf_data = 32'd0;
    if (!Rst) begin
      if (slot_busy) begin
        grf_we   = 1'b1;
        grf_addr = wb_addr;
        grf_data = wb_data;
      end else if (pop) begin
        grf_we   = 1'b1;
        grf_addr = head_addr;
        grf_data = head_data;
      end
    end
  end

  // A new issue to the same register as a retiring pop must stay pending, so set is applied last.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[head_addr] = 1'b0;
    if (iss_valid && (iss_addr != 5'd0))
      pending_next[iss_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lb_addr;
      fifo_data[wr_ptr] <= lb_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= 32'd0;
      age     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW + 1)'(1);
      else if (pop && !push)
        count <= count - (AW + 1)'(1);
      pending <= pending_next;
      // Head age saturates at the limit so stall_req holds until the head finally retires.
      if (fifo_empty || pop)
        age <= '0;
      else if (age < AGE_MAX)
        age <= age + GW'(1);
    end
  end

  assign stall_req = !Rst && (age >= AGE_MAX);
  assign q1_busy   = pending[q1_addr];
  assign q2_busy   = pending[q2_addr];

endmodule
